// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory req/ack handshake, IF/ID register,
// one-entry skid buffer for hazard stalls and branch redirect/flush.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect -> HALT).
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode,
  output logic            misalign
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned OPW  = 7;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1,
    ST_FULL = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   drop_addr_q, drop_addr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [ILEN-1:0]   skid_instr_q, skid_instr_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [ILEN-1:0]   if_instr_q, if_instr_d;
  logic              misalign_q, misalign_d;

  logic              req_c;
  logic [XLEN-1:0]   addr_c;
  logic              ack_c;
  logic [XLEN-1:0]   redirect_tgt_c;
  logic              redirect_bad_c;

  // Request is live in REQ/DROP only; DROP keeps presenting the abandoned address.
  always_comb begin
    req_c  = !rst && ((state_q == ST_REQ) || (state_q == ST_DROP));
    addr_c = (state_q == ST_DROP) ? drop_addr_q : pc_q;
    ack_c  = req_c && imem_ack;
  end

  // Redirect target: low two bits either flag an error or are dropped.
  always_comb begin
    redirect_tgt_c = redirect_pc & ~XLEN'(3);
`ifdef FETCH_MISALIGN_CHK_EN
    redirect_bad_c = |redirect_pc[1:0];
`else
    redirect_bad_c = 1'b0;
`endif
  end

  // Next-state and datapath update; redirect beats ack/stall, HALT is terminal.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    misalign_d   = misalign_q;

    if (state_q == ST_HALT) begin
      state_d = ST_HALT;
    end else if (redirect) begin
      if_valid_d   = 1'b0;
      if_instr_d   = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      if (redirect_bad_c) begin
        misalign_d = 1'b1;
        state_d    = ST_HALT;
      end else begin
        pc_d = redirect_tgt_c;
        if (req_c && !imem_ack) begin
          // Memory still owes us a response for the current address.
          drop_addr_d = addr_c;
          state_d     = ST_DROP;
        end else begin
          state_d = ST_REQ;
        end
      end
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (ack_c) begin
            pc_d = pc_q + XLEN'(4);
            if (!stall) begin
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = ST_FULL;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (!stall) begin
            if_instr_d   = skid_instr_q;
            if_pc_d      = skid_pc_q;
            if_valid_d   = 1'b1;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            state_d      = ST_REQ;
          end
        end
        ST_DROP: begin
          if (ack_c) begin
            state_d = ST_REQ;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      drop_addr_q  <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= NOP_INSTR;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  // Output drive; opcode is zeroed for bubbles so control decodes to all-zero.
  always_comb begin
    imem_req  = req_c;
    imem_addr = addr_c;
    if_valid  = if_valid_q;
    if_pc     = if_pc_q;
    if_instr  = if_instr_q;
    if_opcode = if_valid_q ? if_instr_q[OPW-1:0] : OPW'(0);
    misalign  = misalign_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, stall/skid, redirects, reset, misalign.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_opcode   (if_opcode),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  // Memory: word at 0 is 0x002081B3, elsewhere (addr<<8)|0x13.
  always_comb begin
    if (imem_addr == 32'h0) imem_rdata = 32'h0020_81B3;
    else                    imem_rdata = (imem_addr << 8) | 32'h13;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    cyc(); cyc(); #1;
    chk("rst_req",      32'(imem_req),  32'd0);
    chk("rst_valid",    32'(if_valid),  32'd0);
    chk("rst_pc",       if_pc,          32'd0);
    chk("rst_instr",    if_instr,       32'h13);
    chk("rst_opcode",   32'(if_opcode), 32'd0);
    chk("rst_misalign", 32'(misalign),  32'd0);

    // Zero-wait stream.
    cyc(); rst = 1'b0; imem_ack = 1'b1; #1;
    chk("s0_req",  32'(imem_req), 32'd1);
    chk("s0_addr", imem_addr,     32'h0);
    cyc(); #1;
    chk("s1_addr",   imem_addr,      32'h4);
    chk("s1_valid",  32'(if_valid),  32'd1);
    chk("s1_pc",     if_pc,          32'h0);
    chk("s1_opcode", 32'(if_opcode), 32'h33);
    chk("s1_instr",  if_instr,       32'h0020_81B3);

    // Stall three cycles; word at 8 goes to the skid buffer.
    cyc(); stall = 1'b1; #1;
    chk("st0_addr", imem_addr, 32'h8);
    chk("st0_pc",   if_pc,     32'h4);
    cyc(); #1;
    chk("st1_req",   32'(imem_req), 32'd0);
    chk("st1_pc",    if_pc,         32'h4);
    chk("st1_instr", if_instr,      32'h413);
    cyc(); #1;
    chk("st2_req", 32'(imem_req), 32'd0);
    chk("st2_pc",  if_pc,         32'h4);
    cyc(); stall = 1'b0; #1;
    chk("rel_pc", if_pc, 32'h4);
    cyc(); #1;
    chk("rel1_pc",    if_pc,         32'h8);
    chk("rel1_instr", if_instr,      32'h813);
    chk("rel1_valid", 32'(if_valid), 32'd1);
    chk("rel1_addr",  imem_addr,     32'hC);
    cyc(); redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("rel2_pc",   if_pc,     32'hC);
    chk("rel2_addr", imem_addr, 32'h10);

    // Redirect coincident with ack of 0x10.
    cyc(); redirect = 1'b0; #1;
    chk("rd_valid",  32'(if_valid),  32'd0);
    chk("rd_opcode", 32'(if_opcode), 32'd0);
    chk("rd_instr",  if_instr,       32'h13);
    chk("rd_req",    32'(imem_req),  32'd1);
    chk("rd_addr",   imem_addr,      32'h100);
    cyc(); redirect = 1'b1; redirect_pc = 32'h20; #1;
    chk("rd1_valid", 32'(if_valid), 32'd1);
    chk("rd1_pc",    if_pc,         32'h100);
    chk("rd1_instr", if_instr,      32'h0001_0013);
    chk("rd1_addr",  imem_addr,     32'h104);

    // Redirect while ack for 0x20 is delayed two cycles.
    cyc(); redirect = 1'b1; redirect_pc = 32'h100; imem_ack = 1'b0; #1;
    chk("dr0_addr",  imem_addr,     32'h20);
    chk("dr0_valid", 32'(if_valid), 32'd0);
    cyc(); redirect = 1'b0; #1;
    chk("dr1_req",   32'(imem_req), 32'd1);
    chk("dr1_addr",  imem_addr,     32'h20);
    chk("dr1_valid", 32'(if_valid), 32'd0);
    cyc(); imem_ack = 1'b1; #1;
    chk("dr2_addr", imem_addr, 32'h20);
    cyc(); #1;
    chk("dr3_addr",  imem_addr,     32'h100);
    chk("dr3_valid", 32'(if_valid), 32'd0);
    cyc(); stall = 1'b1; #1;
    chk("dr4_valid", 32'(if_valid), 32'd1);
    chk("dr4_pc",    if_pc,         32'h100);
    chk("dr4_addr",  imem_addr,     32'h104);

    // Reset while the skid buffer is full.
    cyc(); rst = 1'b1; #1;
    chk("full_req", 32'(imem_req), 32'd0);
    cyc(); rst = 1'b0; stall = 1'b0; #1;
    chk("rf_valid",  32'(if_valid),  32'd0);
    chk("rf_opcode", 32'(if_opcode), 32'd0);
    chk("rf_req",    32'(imem_req),  32'd1);
    chk("rf_addr",   imem_addr,      32'h0);
    cyc(); redirect = 1'b1; redirect_pc = 32'h102; #1;
    chk("rf1_valid", 32'(if_valid), 32'd1);
    chk("rf1_pc",    if_pc,         32'h0);
    chk("rf1_instr", if_instr,      32'h0020_81B3);
    chk("rf1_addr",  imem_addr,     32'h4);

    // Misaligned redirect target.
    cyc(); redirect = 1'b0; #1;
    chk("ma_valid", 32'(if_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("ma_flag", 32'(misalign), 32'd1);
    chk("ma_req",  32'(imem_req), 32'd0);
    cyc(); #1;
    chk("ma1_flag", 32'(misalign), 32'd1);
    chk("ma1_req",  32'(imem_req), 32'd0);
`else
    chk("ma_flag", 32'(misalign), 32'd0);
    chk("ma_req",  32'(imem_req), 32'd1);
    chk("ma_addr", imem_addr,     32'h100);
    cyc(); #1;
    chk("ma1_valid", 32'(if_valid), 32'd1);
    chk("ma1_pc",    if_pc,         32'h100);
`endif
    cyc(); rst = 1'b1; #1;
    cyc(); rst = 1'b0; #1;
    chk("end_flag", 32'(misalign), 32'd0);
    chk("end_req",  32'(imem_req), 32'd1);
    chk("end_addr", imem_addr,     32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage with IF/ID pipeline register for the RISC-V datapath. Holds the PC, runs a req/ack handshake with instruction memory, and registers the fetched word. It presents `if_opcode` directly to `Control_Unit.OpCode`. Handles hazard stalls with a one-entry skid buffer and branch redirects (flush) from EX.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC after reset (word-aligned).
- `NOP_INSTR`, 32'h0000_0013: word shown on `if_instr` when invalid (addi x0,x0,0).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: **synchronous, active-high** reset.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, stable while `imem_req` is high and no ack.
- `imem_ack` in 1: data valid. May arrive in the same cycle as `imem_req` (zero-wait) or later.
- `imem_rdata` in 32: instruction word, sampled when `imem_ack` is high.
- `stall` in 1: hazard unit holds IF/ID.
- `redirect` in 1: taken branch from EX (Branch & Zero).
- `redirect_pc` in XLEN: branch target.
- `if_valid` out 1: IF/ID holds a real instruction.
- `if_pc` out XLEN: PC of the IF/ID instruction.
- `if_instr` out 32: IF/ID instruction.
- `if_opcode` out 7: `if_instr[6:0]` when `if_valid`, else 7'b0000000, which makes the Control_Unit emit all-zero controls.
- `misalign` out 1: misaligned-target error, sticky (see Configuration).

## Operation
- **States:**
  - REQ: issuing fetch for `pc`.
  - DROP: waiting for ack of an abandoned request.
  - FULL: skid buffer occupied, no request.
  - HALT: only with the macro.
- `imem_req` = 1 in REQ and DROP, 0 in FULL/HALT and during `rst`. `imem_addr` = `pc`, or the held old address in DROP.
- **Priority per cycle:** `rst` > `redirect` > ack/stall handling.
- **REQ, ack, !stall:** `if_instr`<=`imem_rdata`, `if_pc`<=`pc`, `if_valid`<=1, `pc`<=`pc`+4. Stay in REQ.
- **REQ, ack, stall:** word and PC go to the skid buffer, `pc`<=`pc`+4, ->FULL. IF/ID holds.
- **REQ, no ack:** if !stall then `if_valid`<=0 (bubble); if stall then IF/ID holds.
- **FULL, !stall:** skid -> IF/ID, `if_valid`<=1, ->REQ. **FULL, stall:** hold everything.
- **redirect:**
  - `pc`<=`redirect_pc`, `if_valid`<=0, `if_instr`<=NOP_INSTR, skid cleared. Redirect overrides `stall`.
  - Next state: DROP if a request is outstanding this cycle without ack; otherwise REQ.
- **DROP:** keep old address until ack, discard the data, then ->REQ. A second redirect in DROP updates `pc` only.
- `pc[1:0]` is always 00. `pc`+4 wraps modulo 2^XLEN.

## Timing
- **Reset values:** state REQ, `pc`=RESET_PC, `if_valid`=0, `if_pc`=0, `if_instr`=NOP_INSTR, `if_opcode`=0, `misalign`=0, `imem_req`=0. The first request is in the cycle after `rst` falls.
- **Latency:** ack in cycle N -> `if_*` valid after edge N. Zero-wait memory gives 1 instr/cycle.
- **Stall:** at most one word is captured during a stall. No instruction is lost or duplicated across stall release.
- **Redirect:** flush visible the next cycle. First target address is issued the next cycle (REQ) or after the pending ack (DROP).
- **Reset mid-operation:** any state returns to reset values at the next edge; skid and pending request are abandoned.

## Configuration
- Macro: `FETCH_MISALIGN_CHK_EN`.
- **Defined:** `redirect` with `redirect_pc[1:0]`!=0 sets `misalign`=1 (sticky until `rst`), flushes IF/ID and enters HALT. HALT issues no requests.
- **Undefined:** `misalign` tied 0, and `redirect_pc[1:0]` is ignored (forced 00).

## Test plan
- **Zero-wait stream:** release `rst`, `imem_ack`=1, mem[0]=32'h002081B3.
  - `imem_addr` goes 0,4,8 on consecutive cycles.
  - A cycle later `if_pc`=0, `if_opcode`=7'b0110011, `if_valid`=1.
- **Stall 3 cycles mid-stream:**
  - `if_*` frozen, one word captured into skid, `imem_req`=0 for 2 cycles.
  - After release, `if_pc` goes 8,12,16 with no gap or repeat.
- **Redirect to 0x100 coincident with ack of 0x10:** word at 0x10 never reaches IF/ID, `if_valid`=0 and `if_opcode`=0 next cycle, next `imem_addr`=0x100.
- **Redirect to 0x100 while ack delayed 2 cycles on 0x20:** `imem_addr` stays 0x20 until ack, data dropped, then 0x100 requested.
- **`rst` asserted in FULL:** next cycle `if_valid`=0, `pc`=RESET_PC, skid empty.
- **Macro defined, redirect to 0x102:** `misalign`=1, `imem_req`=0 until `rst`. Macro undefined: fetch at 0x100, `misalign`=0.
